// File: rtl/cp0_unit.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId plus combinational redirect request.
// req and dout are same-cycle combinational; register updates land on the next edge; no backpressure.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPC_out,
    output logic        req
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exccode;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] vpc_adj;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // The live interrupt lines drive the decision; IP is only a sampled copy for software.
    assign int_req = (|(HWInt & im)) & ie & ~exl;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign vpc_adj    = BDIn ? (VPC - 32'd4) : VPC;
    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exccode, 2'd0};
    assign EPC_out    = epc;

    always_comb begin
        dout = 32'd0;
        case (addr)
            5'd12:   dout = sr_word;
            5'd13:   dout = cause_word;
            5'd14:   dout = epc;
            5'd15:   dout = PRID_VALUE;
            default: dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im      <= 6'd0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= 6'd0;
            exccode <= 5'd0;
            epc     <= 32'd0;
        end else begin
            ip <= HWInt;
            if (req) begin
                // The victim is flushed, so any mtc0 or eret in M this cycle is discarded.
                exl     <= 1'b1;
                bd      <= BDIn;
                exccode <= int_req ? 5'd0 : ExcCodeIn;
                epc     <= vpc_adj & 32'hFFFF_FFFC;
            end else begin
                if (en && addr == 5'd12) begin
                    im  <= din[15:10];
                    exl <= din[1];
                    ie  <= din[0];
                end
                if (en && addr == 5'd14) begin
                    epc <= din & 32'hFFFF_FFFC;
                end
                // Placed after the mtc0 write so eret wins on EXL when both hit SR.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios followed by random traffic against a word-level model.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2023_0007;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPC_out;
    logic        req;

    int vectors     = 0;
    int miscompares = 0;

    // Model state kept as whole architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;

    always #5 clk = ~clk;

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .din(din), .dout(dout),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .EPC_out(EPC_out), .req(req)
    );

    function automatic logic model_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b0; addr = 5'd0; din = 32'd0; VPC = 32'd0; BDIn = 1'b0;
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance the model across one rising edge.
    task automatic cycle();
        logic [31:0] n_sr, n_cause, n_epc;
        logic        r, i;
        @(negedge clk);
        r = model_req();
        i = model_int();
        chk("req", {31'd0, req}, {31'd0, r});
        chk("dout", dout, model_rd(addr));
        chk("epc_out", EPC_out, m_epc);
        n_sr = m_sr; n_epc = m_epc;
        if (r) begin
            n_sr    = m_sr | 32'h2;
            n_cause = ({31'd0, BDIn} << 31) | ({26'd0, HWInt} << 10) |
                      (i ? 32'd0 : ({27'd0, ExcCodeIn} << 2));
            n_epc   = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;
        end else begin
            n_cause = (m_cause & ~(32'h3F << 10)) | ({26'd0, HWInt} << 10);
            if (en && addr == 5'd12) n_sr  = din & 32'h0000_FC03;
            if (en && addr == 5'd14) n_epc = din & ~32'd3;
            if (EXLClr) n_sr = n_sr & ~32'h2;
        end
        @(posedge clk);
        #1;
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    // Asynchronous reset pulse away from the edge; outputs must clear without a clock.
    task automatic reset_mid(input logic [4:0] code);
        @(posedge clk);
        #2;
        idle();
        ExcCodeIn = code;
        reset = 1'b1;
        #1;
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        chk("rst_req", {31'd0, req}, {31'd0, code != 5'd0});
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        rd(5'd15, "rst_prid", PRID);
        chk("rst_epc_out", EPC_out, 32'd0);
        ExcCodeIn = 5'd0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_mid(5'd0);

        // Overflow exception outside a delay slot.
        VPC = 32'h0000_3010; BDIn = 1'b0; ExcCodeIn = 5'd12;
        #1 chk("ovf_req", {31'd0, req}, 32'd1);
        cycle();
        idle();
        chk("ovf_epc", EPC_out, 32'h0000_3010);
        rd(5'd13, "ovf_cause", 32'h0000_0030);
        rd(5'd12, "ovf_sr", 32'h0000_0002);

        // eret, then a delay-slot exception, then a masked one.
        EXLClr = 1'b1;
        cycle();
        idle();
        VPC = 32'h0000_3024; BDIn = 1'b1; ExcCodeIn = 5'd10;
        #1 chk("ds_req", {31'd0, req}, 32'd1);
        cycle();
        idle();
        chk("ds_epc", EPC_out, 32'h0000_3020);
        rd(5'd13, "ds_cause", 32'h8000_0028);
        VPC = 32'h0000_5000; ExcCodeIn = 5'd4;
        #1 chk("masked_req", {31'd0, req}, 32'd0);
        cycle();
        idle();
        chk("masked_epc", EPC_out, 32'h0000_3020);

        // Interrupt beats a simultaneous exception.
        EXLClr = 1'b1;
        cycle();
        idle();
        en = 1'b1; addr = 5'd12; din = 32'h0000_0401;
        cycle();
        idle();
        HWInt = 6'b000001; ExcCodeIn = 5'd8; VPC = 32'h0000_4000;
        #1 chk("int_req", {31'd0, req}, 32'd1);
        cycle();
        idle();
        rd(5'd13, "int_cause", 32'h0000_0400);

        // eret with an interrupt pending: req rises right after the eret edge.
        HWInt = 6'b000001; EXLClr = 1'b1;
        #1 chk("eret_req_masked", {31'd0, req}, 32'd0);
        cycle();
        EXLClr = 1'b0; VPC = 32'h0000_4100;
        #1 chk("eret_req_rise", {31'd0, req}, 32'd1);
        rd(5'd12, "eret_sr", 32'h0000_0401);
        chk("eret_epc_hold", EPC_out, 32'h0000_4000);
        cycle();
        idle();
        chk("reint_epc", EPC_out, 32'h0000_4100);

        // IE=0 gates interrupts, IP still samples the lines.
        EXLClr = 1'b1;
        cycle();
        idle();
        en = 1'b1; addr = 5'd12; din = 32'h0000_0400;
        cycle();
        idle();
        HWInt = 6'b000001;
        #1 chk("ie0_req", {31'd0, req}, 32'd0);
        cycle();
        rd(5'd13, "ie0_ip", 32'h0000_0400);
        idle();

        // mtc0 EPC alignment, and mtc0 SR dropped by a colliding exception.
        en = 1'b1; addr = 5'd14; din = 32'h0000_3007;
        cycle();
        idle();
        rd(5'd14, "epc_wr", 32'h0000_3004);
        en = 1'b1; addr = 5'd12; din = 32'h0000_FC01; ExcCodeIn = 5'd3; VPC = 32'h0000_6000;
        cycle();
        idle();
        rd(5'd12, "sr_drop", 32'h0000_0402);

        // mtc0 SR together with eret: written fields with EXL cleared.
        en = 1'b1; addr = 5'd12; din = 32'hFFFF_FFFF; EXLClr = 1'b1;
        cycle();
        idle();
        rd(5'd12, "sr_eret", 32'h0000_FC01);

        // VPC-4 wraps at zero.
        VPC = 32'd0; BDIn = 1'b1; ExcCodeIn = 5'd1;
        cycle();
        idle();
        chk("wrap_epc", EPC_out, 32'hFFFF_FFFC);

        reset_mid(5'd7);

        for (int n = 0; n < 400; n++) begin
            HWInt     = 6'($urandom);
            ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            BDIn      = 1'($urandom);
            VPC       = $urandom;
            en        = ($urandom_range(0, 2) == 0);
            addr      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(10 + $urandom_range(0, 6));
            din       = $urandom;
            EXLClr    = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception controller: the producer side of the NPC's exception redirect interface. It holds SR, Cause, EPC and PRId. Each cycle it inspects the instruction at the commit (M) stage plus the hardware interrupt lines. It drives `req`, which redirects fetch to the handler at 0x00004180, and `EPC_out`, which eret uses as its return address. It sits beside the M stage and serves mfc0/mtc0 accesses.

## Interface
- `PRID_VALUE`, default 32'h2023_0007: read-only value returned for register 15.
- `clk` input 1: single clock, all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `en` input 1: mtc0 write strobe from the M stage.
- `addr` input 5: CP0 register number for both read and write.
- `din` input 32: mtc0 write data.
- `dout` output 32: mfc0 read data, combinational from `addr`.
- `VPC` input 32: PC of the instruction currently in M (victim PC).
- `BDIn` input 1: the M instruction is in a branch delay slot.
- `ExcCodeIn` input 5: exception code of the M instruction; 0 means none.
- `HWInt` input 6: external interrupt lines, level-sensitive.
- `EXLClr` input 1: eret committing in M.
- `EPC_out` output 32: current EPC register.
- `req` output 1: take exception/interrupt this cycle; combinational.

## Operation
- **SR (reg 12).**
  - Fields: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Writable by mtc0 in those fields only.
- **Cause (reg 13).**
  - Fields: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - Read-only to mtc0; writes are ignored.
- **EPC (reg 14).** Full 32 bits, writable by mtc0. Bits [1:0] are always stored as 0.
- **PRId (reg 15).** Returns `PRID_VALUE`.
- **Unmapped reads.** Any other `addr` reads 0.
- **Request generation.**
  - IntReq = |(HWInt & IM) & IE & !EXL.
  - ExcReq = (ExcCodeIn != 0) & !EXL.
  - req = IntReq | ExcReq.
- **Priority.** Interrupt beats a synchronous exception.
- **On req (clock edge):**
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= (BDIn ? VPC-4 : VPC) with [1:0] forced to 0.
- **IP.** IP <= HWInt every cycle, unconditionally, including cycles with req.
- **eret.** When `EXLClr`=1 and req=0, EXL <= 0 on the edge. All other fields are unchanged.
- **Simultaneous events:**
  - req and `en` in the same cycle: the mtc0 write is dropped, because the victim is flushed.
  - req and `EXLClr`: cannot both be 1, since EXLClr implies EXL=1, which masks req. If forced, req wins.
  - `en` writing SR together with `EXLClr`: the mtc0 value applies first, then EXL is cleared. Net result: SR = din fields with EXL=0.
  - `en` writing EPC with `EXLClr`: the write takes effect.
- **Arithmetic.** VPC-4 is 32-bit and wraps modulo 2^32 (VPC=0 gives 0xFFFFFFFC).
- **Reset value of every output:**
  - SR, Cause and EPC = 0.
  - `EPC_out` = 0.
  - `req` = 0 provided ExcCodeIn=0. With IE=0, interrupts cannot fire after reset.
  - `dout` per `addr` on the cleared state.
- **Reset mid-operation.** Asynchronous reset mid-exception clears EXL immediately; req then depends only on ExcCodeIn.

## Timing
- **req latency.** req is combinational, in the same cycle that the qualifying ExcCodeIn, HWInt or SR state is present.
- **Register updates.** They become visible on `dout` and `EPC_out` one cycle after the triggering edge.
- **mfc0 reads.** Combinational, with no bypass. A read in the cycle of an mtc0 write returns the old value; the new value appears the next cycle.
- **Masking after entry.** After req, EXL=1 from the next cycle, masking further req until eret commits.
- **Re-enable after eret.** A pending interrupt may fire the cycle after the eret edge.
- **HWInt sampling.** HWInt is sampled every edge into IP. The req decision uses live HWInt, not IP.

## Test plan
- **Reset state.** Assert reset mid-cycle, then read addr 12/13/14/15 → 0, 0, 0, 32'h2023_0007; req=0 with ExcCodeIn=0.
- **Overflow exception.** Set VPC=0x00003010, BDIn=0, ExcCodeIn=12 for one cycle → req=1 that cycle. Next cycle: EPC_out=0x00003010, Cause=0x00000030, SR.EXL=1.
- **Delay-slot exception.** Set VPC=0x00003024, BDIn=1, ExcCodeIn=10 → EPC=0x00003020, Cause=0x80000028. A second exception while EXL=1 gives req=0 and leaves EPC unchanged.
- **Interrupt gating and priority.**
  - mtc0 SR=0x00000401, HWInt=6'b000001 → req=1, ExcCode=0.
  - Same cycle with ExcCodeIn=8 → ExcCode still 0.
  - With SR=0x00000400 (IE=0) → req=0, but Cause.IP still reads 0x00000400.
- **mtc0 collision.** mtc0 EPC=0x00003007 alone → reads back 0x00003004. mtc0 SR together with req → the write is dropped.
- **eret.** With EXL=1, pulse EXLClr while HWInt is asserted and IM/IE are set. EXL reads 0 next cycle, and req rises in that same next cycle; EPC is unchanged until the new entry edge.
